// File: rtl/mor1kx_dpram_port_ctrl_if.sv
// Request/response bundle between a pipeline client and its RAM port controller.
// The client side uses the master modport, the controller uses the slave modport.
interface mor1kx_dpram_port_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [NB-1:0]         req_be_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_be_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_be_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o
  );
endinterface

// File: rtl/mor1kx_dpram_port_ctrl.sv
// Port controller for one port of a synchronous-read, write-first dual-port RAM.
// Byte-masked writes become read-modify-write sequences; responses go through a
// 2-entry FIFO so the client can stall them.
// Optional macro MOR1KX_DPRAM_CTRL_BYPASS_EN: when the FIFO is empty, a RAM
// result is presented combinationally on the response port (1-cycle latency).
//
// state  | meaning
// IDLE   | accepting requests; RAM port follows the request address
// RMW_RD | RAM read data of a partial write is merged and registered
// RMW_WR | merged word is written back; its write-first dout is the response
module mor1kx_dpram_port_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mor1kx_dpram_port_ctrl_if.slave bus,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [DATA_WIDTH-1:0] ram_din_o,
  input  logic [DATA_WIDTH-1:0] ram_dout_i
);
  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RMW_RD = 2'd1,
    RMW_WR = 2'd2
  } state_t;

  state_t                state_q;
  logic                  due_q;        // ram_dout_i carries a response this cycle
  logic [ADDR_WIDTH-1:0] lat_addr_q;
  logic [NB-1:0]         lat_be_q;
  logic [DATA_WIDTH-1:0] lat_wdata_q;
  logic [DATA_WIDTH-1:0] merged_q;

  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            cnt_q;

  logic [1:0]            occ;
  logic                  req_ready;
  logic                  accept;
  logic                  be_full;
  logic                  be_zero;
  logic                  is_partial;
  logic                  is_full_wr;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] merged;

  // The in-flight result is counted so it always has a FIFO slot waiting for it.
  assign occ        = cnt_q + {1'b0, due_q};
  assign req_ready  = rst_n && (state_q == IDLE) && (occ < 2'd2);
  assign accept     = bus.req_valid_i && req_ready;
  assign be_full    = &bus.req_be_i;
  assign be_zero    = ~|bus.req_be_i;
  assign is_partial = bus.req_we_i && !be_zero && !be_full;
  assign is_full_wr = bus.req_we_i && be_full;

  assign bus.req_ready_o = req_ready;

  // Byte merge of the latched write data over the word just read from RAM.
  always_comb begin
    merged = ram_dout_i;
    for (int i = 0; i < NB; i++) begin
      if (lat_be_q[i]) merged[8*i +: 8] = lat_wdata_q[8*i +: 8];
    end
  end

  // RAM port drive: follows the request in IDLE, the latched word during RMW.
  always_comb begin
    ram_addr_o = bus.req_addr_i;
    ram_we_o   = 1'b0;
    ram_din_o  = bus.req_wdata_i;
    case (state_q)
      IDLE: begin
        if (accept && is_full_wr) ram_we_o = 1'b1;
      end
      RMW_RD: begin
        ram_addr_o = lat_addr_q;
      end
      RMW_WR: begin
        ram_addr_o = lat_addr_q;
        ram_din_o  = merged_q;
        ram_we_o   = rst_n;
      end
      default: begin
        ram_addr_o = bus.req_addr_i;
      end
    endcase
  end

`ifdef MOR1KX_DPRAM_CTRL_BYPASS_EN
  logic bypass_active;

  // Empty FIFO and a result on the RAM bus: hand it straight to the client.
  always_comb begin
    bypass_active   = (cnt_q == 2'd0) && due_q;
    bus.rsp_valid_o = (cnt_q != 2'd0) || due_q;
    bus.rsp_rdata_o = bypass_active ? ram_dout_i : fifo_mem[rd_ptr_q];
    push            = due_q && !(bypass_active && bus.rsp_ready_i);
    pop             = (cnt_q != 2'd0) && bus.rsp_ready_i;
  end
`else
  // All responses come out of the FIFO registers.
  always_comb begin
    bus.rsp_valid_o = (cnt_q != 2'd0);
    bus.rsp_rdata_o = fifo_mem[rd_ptr_q];
    push            = due_q;
    pop             = (cnt_q != 2'd0) && bus.rsp_ready_i;
  end
`endif

  // Sequencer: tracks the RMW phases and which cycles return a response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      due_q       <= 1'b0;
      lat_addr_q  <= '0;
      lat_be_q    <= '0;
      lat_wdata_q <= '0;
      merged_q    <= '0;
    end else begin
      due_q <= ((state_q == IDLE) && accept && !is_partial) || (state_q == RMW_WR);
      case (state_q)
        IDLE: begin
          if (accept && is_partial) begin
            lat_addr_q  <= bus.req_addr_i;
            lat_be_q    <= bus.req_be_i;
            lat_wdata_q <= bus.req_wdata_i;
            state_q     <= RMW_RD;
          end
        end
        RMW_RD: begin
          merged_q <= merged;
          state_q  <= RMW_WR;
        end
        RMW_WR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Response FIFO: two entries, push and pop may coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= ram_dout_i;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: tb/tb_mor1kx_dpram_port_ctrl.sv
// Directed bench for mor1kx_dpram_port_ctrl with a write-first synchronous RAM model.
module tb_mor1kx_dpram_port_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic [31:0] ram [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;
  int          we_cnt = 0;

  int n_vec = 0;
  int n_err = 0;

`ifdef MOR1KX_DPRAM_CTRL_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  mor1kx_dpram_port_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  mor1kx_dpram_port_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ram_addr_o (ram_addr),
    .ram_we_o   (ram_we),
    .ram_din_o  (ram_din),
    .ram_dout_i (ram_dout)
  );

  always #5 clk = ~clk;

  // Write-first synchronous RAM port, with a preload path for the bench.
  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (ram_we) begin
      ram[ram_addr] <= ram_din;
      ram_dout      <= ram_din;
    end else begin
      ram_dout <= ram[ram_addr];
    end
    if (ram_we === 1'b1) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    step();
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  // Waits (bounded) for a response, takes it and moves into the next cycle.
  task automatic get_rsp(output logic [31:0] d);
    d = 32'hxxxxxxxx;
    bus.rsp_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.rsp_valid_o === 1'b1) begin
        d = bus.rsp_rdata_o;
        step(); bus.req_valid_i = 1'b0; #1;
        return;
      end
      step(); bus.req_valid_i = 1'b0; #1;
    end
  endtask

  task automatic issue(input logic we, input logic [7:0] a, input logic [3:0] be,
                       input logic [31:0] wd);
    step();
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_addr_i = a;
    bus.req_be_i = be; bus.req_wdata_i = wd;
    #1;
  endtask

  initial begin
    logic [31:0] d;
    int          lat;
    int          we0;
    int          acc;
    logic        a;

    rst_n = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = '0;
    bus.req_be_i = '0; bus.req_wdata_i = '0; bus.rsp_ready_i = 1'b0;

    preload(8'h10, 32'hDEADBEEF);
    preload(8'h20, 32'h00000000);
    preload(8'h30, 32'hAABBCCDD);
    preload(8'h40, 32'h5A5A5A5A);
    preload(8'h50, 32'h00000000);
    for (int i = 0; i < 4; i++) preload(8'(8'h60 + i), 32'h600 + 32'(i));
    #1;
    chk("reset_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
    chk("reset_rsp_rdata", 64'(bus.rsp_rdata_o), 64'(0));
    chk("reset_ram_we",    64'(ram_we), 64'(0));

    step(); rst_n = 1'b1; #1;
    chk("idle_ready", 64'(bus.req_ready_o), 64'(1));

    // Single read of 0x10
    we0 = we_cnt;
    bus.rsp_ready_i = 1'b1;
    issue(1'b0, 8'h10, 4'h0, 32'h0);
    chk("rd_accept_addr", 64'(ram_addr), 64'(8'h10));
    chk("rd_accept_we",   64'(ram_we), 64'(0));
    step(); bus.req_valid_i = 1'b0; #1;
    lat = 1;
    while (bus.rsp_valid_o !== 1'b1 && lat < 10) begin
      step(); #1; lat++;
    end
    chk("rd_latency", 64'(lat), 64'(LAT));
    chk("rd_data", 64'(bus.rsp_rdata_o), 64'(32'hDEADBEEF));
    step(); #1;
    chk("rd_single_beat", 64'(bus.rsp_valid_o), 64'(0));
    chk("rd_no_ram_write", 64'(we_cnt - we0), 64'(0));

    // Full write then back-to-back read of the same address
    issue(1'b1, 8'h20, 4'hF, 32'h12345678);
    chk("fw_ready", 64'(bus.req_ready_o), 64'(1));
    chk("fw_ram_we", 64'(ram_we), 64'(1));
    chk("fw_ram_din", 64'(ram_din), 64'(32'h12345678));
    issue(1'b0, 8'h20, 4'h0, 32'h0);
    chk("fw_rd_no_stall", 64'(bus.req_ready_o), 64'(1));
    get_rsp(d);
    chk("fw_rsp", 64'(d), 64'(32'h12345678));
    get_rsp(d);
    chk("fw_rd_rsp", 64'(d), 64'(32'h12345678));
    chk("fw_ram_content", 64'(ram[8'h20]), 64'(32'h12345678));

    // Partial write: read-modify-write of 0x30
    issue(1'b1, 8'h30, 4'b0101, 32'h11223344);
    chk("rmw_accept_we", 64'(ram_we), 64'(0));
    chk("rmw_accept_addr", 64'(ram_addr), 64'(8'h30));
    step(); bus.req_valid_i = 1'b0; #1;
    chk("rmw_rd_ready", 64'(bus.req_ready_o), 64'(0));
    chk("rmw_rd_we", 64'(ram_we), 64'(0));
    step(); #1;
    chk("rmw_wr_ready", 64'(bus.req_ready_o), 64'(0));
    chk("rmw_wr_we", 64'(ram_we), 64'(1));
    chk("rmw_wr_din", 64'(ram_din), 64'(32'hAA22CC44));
    step(); #1;
    chk("rmw_done_ready", 64'(bus.req_ready_o), 64'(1));
    get_rsp(d);
    chk("rmw_rsp", 64'(d), 64'(32'hAA22CC44));
    chk("rmw_ram_content", 64'(ram[8'h30]), 64'(32'hAA22CC44));

    // Backpressure: four reads offered, two fit
    bus.rsp_ready_i = 1'b0;
    issue(1'b0, 8'h60, 4'h0, 32'h0);
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      a = bus.req_valid_i && bus.req_ready_o;
      step();
      if (a) begin
        acc++;
        bus.req_addr_i = bus.req_addr_i + 8'd1;
      end
      #1;
    end
    bus.req_valid_i = 1'b0;
    chk("bp_accepted", 64'(acc), 64'(2));
    chk("bp_ready_low", 64'(bus.req_ready_o), 64'(0));
    get_rsp(d);
    chk("bp_rsp0", 64'(d), 64'(32'h600));
    get_rsp(d);
    chk("bp_rsp1", 64'(d), 64'(32'h601));
    chk("bp_no_dup", 64'(bus.rsp_valid_o), 64'(0));
    chk("bp_ready_back", 64'(bus.req_ready_o), 64'(1));

    // Write with no byte enables behaves as a read
    we0 = we_cnt;
    issue(1'b1, 8'h40, 4'h0, 32'hFFFFFFFF);
    chk("be0_we", 64'(ram_we), 64'(0));
    get_rsp(d);
    chk("be0_rsp", 64'(d), 64'(32'h5A5A5A5A));
    chk("be0_no_write", 64'(we_cnt - we0), 64'(0));
    chk("be0_ram_content", 64'(ram[8'h40]), 64'(32'h5A5A5A5A));

    // Reset during RMW_RD drops the pending write
    we0 = we_cnt;
    issue(1'b1, 8'h50, 4'b0001, 32'h000000FF);
    step(); bus.req_valid_i = 1'b0; rst_n = 1'b0; #1;
    chk("rst_rmw_we", 64'(ram_we), 64'(0));
    step(); step(); #1;
    chk("rst_rmw_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
    step(); rst_n = 1'b1; #1;
    chk("rst_rmw_ready", 64'(bus.req_ready_o), 64'(1));
    step(); #1;
    chk("rst_rmw_no_write", 64'(we_cnt - we0), 64'(0));
    chk("rst_rmw_ram_content", 64'(ram[8'h50]), 64'(0));
    chk("rst_rmw_rsp_still_0", 64'(bus.rsp_valid_o), 64'(0));
    issue(1'b0, 8'h50, 4'h0, 32'h0);
    get_rsp(d);
    chk("rst_rmw_readback", 64'(d), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mor1kx_dpram_port_ctrl.md
Name: mor1kx_dpram_port_ctrl

Overview:
Initiator-side controller that drives one port of the team's true dual-port, synchronous-read, write-first RAM on behalf of a valid/ready request/response client. It converts byte-masked writes into read-modify-write sequences, because the RAM has no byte enables, and absorbs the RAM's one-cycle read latency. It also buffers responses so the client can apply backpressure. One instance sits in front of each RAM port that a pipeline unit, such as the store buffer or the cache refill logic, needs to own.

Parameters:
ADDR_WIDTH, 8, RAM word-address width.
DATA_WIDTH, 32, word width; must be a multiple of 8. Byte lanes NB = DATA_WIDTH/8.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous reset, active-low
req_valid_i  input  1  request present
req_ready_o  output  1  request accepted this cycle when both req_valid_i and req_ready_o are high
req_we_i  input  1  1 = write, 0 = read
req_addr_i  input  ADDR_WIDTH  word address
req_be_i  input  NB  byte enables; ignored for reads
req_wdata_i  input  DATA_WIDTH  write data
rsp_valid_o  output  1  response present
rsp_ready_i  input  1  response consumed when both rsp_valid_o and rsp_ready_i are high
rsp_rdata_o  output  DATA_WIDTH  read data, or final merged word for writes
ram_addr_o  output  ADDR_WIDTH  to RAM port addr
ram_we_o  output  1  to RAM port we
ram_din_o  output  DATA_WIDTH  to RAM port din
ram_dout_i  input  DATA_WIDTH  from RAM port dout; registered, write-first

Behaviour:
- Every accepted request produces exactly one response. Responses are returned in acceptance order.
- Response buffer: 2-entry FIFO. Let occ = buffered entries + 1 if a RAM result is due next cycle.
- req_ready_o = (state == IDLE) && (occ < 2); it does not depend on req_valid_i. A response popped in the same cycle does not free a slot until the next cycle.
- State machine has three states: IDLE, RMW_RD, RMW_WR.
- IDLE, read accepted (we=0, or we=1 with be==0): ram_addr_o = req_addr_i and ram_we_o = 0 in the accept cycle. ram_dout_i is pushed into the FIFO at the next edge. rsp_valid_o rises 2 cycles after the accept edge. Throughput is 1 per cycle while rsp_ready_i is held high.
- IDLE, full write accepted (be all ones): ram_we_o = 1 and ram_din_o = req_wdata_i in the accept cycle. The RAM's write-first dout (= wdata) is pushed as the response the following cycle.
- IDLE, partial write accepted (be nonzero and not all ones): latch addr, be and wdata, and issue a RAM read in the accept cycle; go to RMW_RD.
- RMW_RD (1 cycle): ram_addr_o = latched addr, ram_we_o = 0, and compute merged[byte i] = be[i] ? wdata[byte i] : ram_dout_i[byte i]. Register the merged word and go to RMW_WR.
- RMW_WR (1 cycle): ram_we_o = 1, ram_din_o = merged word, ram_addr_o = latched addr. The RAM's write-first dout is pushed as the response next cycle. Return to IDLE.
- In both RMW states, req_ready_o = 0.
- When idle with no request, ram_addr_o follows req_addr_i and ram_we_o = 0.
- A read accepted the cycle after a write to the same address returns the new data; no stall is needed.
- FIFO full with rsp_ready_i = 0: no acceptance and no loss; the in-flight result always has a reserved slot.
- Simultaneous FIFO push and pop is allowed and leaves occupancy unchanged.
- Reset values: state = IDLE, FIFO empty, no in-flight result, rsp_valid_o = 0, ram_we_o = 0, rsp_rdata_o = 0.
- Reset mid-RMW discards the pending write; RAM contents are left untouched.
- Ordering against the other RAM port (a different initiator) is outside this block's scope.

Optional Feature:
MOR1KX_DPRAM_CTRL_BYPASS_EN:
- When defined: if the FIFO is empty and a RAM result is due, ram_dout_i is driven combinationally onto rsp_rdata_o with rsp_valid_o = 1. If rsp_ready_i = 1 in that cycle, the result is not pushed. Response latency becomes 1 cycle and req_ready_o is unchanged.
- When undefined: all responses are registered and latency is 2 cycles.

Test Plan:
- Reset, then read addr 0x10 holding 0xDEADBEEF with rsp_ready_i = 1 -> rsp_valid_o one cycle, 2 cycles after accept (1 with BYPASS_EN), rsp_rdata_o = 0xDEADBEEF, ram_we_o never high.
- Full write 0x12345678 to 0x20, then read 0x20 back-to-back -> write response 0x12345678 then read response 0x12345678, no stall cycles.
- RAM[0x30] = 0xAABBCCDD, write wdata 0x11223344 with be 4'b0101 -> RMW_RD then RMW_WR, req_ready_o low 2 cycles, RAM[0x30] = 0xAA22CC44, response 0xAA22CC44.
- 4 reads issued with rsp_ready_i = 0 -> only 2 accepted, req_ready_o low thereafter. Releasing rsp_ready_i returns data in order with no loss or duplication.
- Write with be = 0 to 0x40 holding 0x5A5A5A5A -> no RAM write, response 0x5A5A5A5A.
- rst_n low during RMW_RD of a be 4'b0001 write to 0x50 holding 0x00000000 -> RAM[0x50] stays 0, rsp_valid_o = 0, and state returns to IDLE after reset.
